demux4_stream: RTL

- 1-to-4 stream demultiplexer with valid/ready handshaking on both sides.
- Each accepted 32-bit word is steered to one of four output lanes by a 2-bit select.
- Each lane buffers words in its own small FIFO, so a stalled consumer does not stall the other lanes.
- Sits opposite the datapath 4-to-1 select mux; used to dispatch results and writeback data to four consumers.

---
 rtl/demux4_stream.sv | 103 ++++++++++
 1 files changed

// File: rtl/demux4_stream.sv
// rtl/demux4_stream.sv - 1-to-4 stream demultiplexer with a small FIFO per output lane
//
// Purpose: each word accepted on the input stream is steered by in_select
// into one of four lane FIFOs. Every lane drains independently, so a stalled
// consumer only back-pressures words that are aimed at its own lane.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             synchronous clear of all lanes (datapath only)
//   in_valid/in_ready producer handshake; in_select picks the lane, in_data is the word
//   out_valid[3:0]    lane i has a head word on out_data<i>
//   out_ready[3:0]    consumer i takes the head word of lane i
//   out_data0..3      registered head word of each lane
//   lane_count        per-lane occupancy, lane i in slice i
module demux4_stream #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     in_select,
  input  logic [WIDTH-1:0]               in_data,
  output logic [3:0]                     out_valid,
  input  logic [3:0]                     out_ready,
  output logic [WIDTH-1:0]               out_data0,
  output logic [WIDTH-1:0]               out_data1,
  output logic [WIDTH-1:0]               out_data2,
  output logic [WIDTH-1:0]               out_data3,
  output logic [4*($clog2(DEPTH)+1)-1:0] lane_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q  [4][DEPTH];
  logic [PW-1:0]    wptr_q [4];
  logic [PW-1:0]    wptr_d [4];
  logic [PW-1:0]    rptr_q [4];
  logic [PW-1:0]    rptr_d [4];
  logic [CW-1:0]    cnt_q  [4];
  logic [CW-1:0]    cnt_d  [4];
  logic [3:0]       full;
  logic [3:0]       push_lane;
  logic [3:0]       pop_lane;

  // Status is derived from registered counts only, so in_ready never sees out_ready.
  always_comb begin
    full       = '0;
    out_valid  = '0;
    lane_count = '0;
    for (int i = 0; i < 4; i++) begin
      full[i]               = (cnt_q[i] == CW'(DEPTH));
      out_valid[i]          = (cnt_q[i] != '0);
      lane_count[i*CW +: CW] = cnt_q[i];
    end
  end

  assign in_ready = ~full[in_select];

  always_comb begin
    push_lane = '0;
    pop_lane  = '0;
    for (int i = 0; i < 4; i++) begin
      wptr_d[i]    = wptr_q[i];
      rptr_d[i]    = rptr_q[i];
      push_lane[i] = in_valid && in_ready && (in_select == 2'(i));
      pop_lane[i]  = out_valid[i] && out_ready[i];
      if (push_lane[i]) wptr_d[i] = wptr_q[i] + PW'(1);
      if (pop_lane[i])  rptr_d[i] = rptr_q[i] + PW'(1);
      // Push and pop together leave the count unchanged.
      cnt_d[i] = cnt_q[i] + CW'(push_lane[i]) - CW'(pop_lane[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < 4; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
        if (push_lane[i]) mem_q[i][wptr_q[i]] <= in_data;
      end
    end
  end

  assign out_data0 = mem_q[0][rptr_q[0]];
  assign out_data1 = mem_q[1][rptr_q[1]];
  assign out_data2 = mem_q[2][rptr_q[2]];
  assign out_data3 = mem_q[3][rptr_q[3]];

endmodule
